conv_job_sequencer: RTL and testbench
=====================================

CONV_JOB_SEQUENCER -- requirements
Module: conv_job_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 14, memory-interface address width; DATA_WIDTH, default 32, word width; LOAD_WORDS, default 288, words per job; RESULT_BASE, default 14'h120, first result address; RESULT_WORDS, default 2, result words per job; POLL_LIMIT, default 100000, poll cycles before timeout.
REQ-002 SHALL have ports: i_clk in 1, sole clock; i_rst in 1, synchronous active-high reset.
REQ-003 SHALL have job-control ports: i_go in 1, job start pulse; o_busy out 1, job in progress; o_done out 1, one-cycle end-of-job pulse; o_err out 1, sticky timeout flag.
REQ-004 SHALL have an input stream: s_valid in 1; s_ready out 1; s_data in DATA_WIDTH, kernel and feature words in address order.
REQ-005 SHALL have a memory-interface bus: o_we out 1; o_re out 1; o_write_addr out ADDR_WIDTH; o_read_addr out ADDR_WIDTH; o_data out DATA_WIDTH; i_rdata in DATA_WIDTH, valid one cycle after o_re/o_read_addr.
REQ-006 SHALL have a result stream: m_valid out 1; m_ready in 1; m_data out DATA_WIDTH; m_last out 1.

Function
REQ-007 SHALL implement the states IDLE, LOAD, CLEAR, START, POLL, RADDR, RWAIT, DRAIN and DONE.
REQ-008 IDLE: i_go moves to LOAD and clears o_err; i_go in any other state SHALL be ignored.
REQ-009 LOAD: s_ready=1; each s_valid&&s_ready handshake SHALL register o_we=1, o_write_addr=word index (0..LOAD_WORDS-1) and o_data=s_data for the next cycle; o_we SHALL be 0 on non-handshake cycles.
REQ-010 After handshake LOAD_WORDS-1, s_ready SHALL drop in the same cycle and the FSM SHALL enter CLEAR.
REQ-011 CLEAR SHALL drive one cycle of o_we=1, o_write_addr=3FFD, o_data=0; START SHALL then drive one cycle of o_we=1, o_write_addr=3FFE, o_data=1.
REQ-012 POLL: o_re=1, o_read_addr=3FFF; i_rdata SHALL be sampled from the second POLL cycle onward; i_rdata==1 SHALL move the FSM to RADDR.
REQ-013 RADDR SHALL drive o_re=1, o_read_addr=RESULT_BASE+k for k=0..RESULT_WORDS-1; RWAIT SHALL capture i_rdata into m_data and assert m_valid.
REQ-014 DRAIN SHALL hold m_valid and m_data stable until m_ready; m_last=1 SHALL accompany k=RESULT_WORDS-1; after the handshake the FSM SHALL go to RADDR (k+1) or to DONE after the last word.
REQ-015 DONE SHALL pulse o_done for exactly one cycle and return to IDLE; o_busy=1 in every state except IDLE.
REQ-016 o_we and o_re SHALL never be asserted in the same cycle; o_re=0 outside POLL and RADDR.
REQ-017 Counters SHALL be wide enough for LOAD_WORDS, RESULT_WORDS and POLL_LIMIT without wrap; RESULT_BASE+k SHALL be computed modulo 2^ADDR_WIDTH.

Reset
REQ-018 i_rst SHALL force IDLE and drive o_we, o_re, s_ready, m_valid, m_last, o_busy, o_done and o_err to 0, and all addresses and data to 0, on the next edge.
REQ-019 Reset mid-job SHALL abandon the job without further bus cycles; the next job's CLEAR write restarts the downstream block.

Configuration
REQ-020 With CONV_SEQ_TIMEOUT_EN defined, POLL SHALL count cycles; on reaching POLL_LIMIT it SHALL set o_err=1 and go to DONE with no result words.
REQ-021 Without CONV_SEQ_TIMEOUT_EN, POLL SHALL wait indefinitely and o_err SHALL be tied 0.

Structure
REQ-022 Package conv_seq_pkg SHALL hold the state enum and the control-register address constants (CLEAR 3FFD, START 3FFE, DONE 3FFF).
REQ-023 The block SHALL contain one sub-module, conv_seq_rd_buf: a one-entry result holding register with valid/ready handshake.

Verification
REQ-024 Scenario: i_go, then 288 words with s_valid held high -> 288 writes to addresses 0..287 on consecutive cycles, then writes 3FFD=0 and 3FFE=1.
REQ-025 Scenario: model raises done after 50 poll cycles, results are 0xAAAA5555 and 0x0F0F0F0F -> reads of 120 and 121, m_data in that order, m_last on the second, then one o_done pulse.
REQ-026 Scenario: m_ready held low for 10 cycles on word 0 -> m_valid and m_data stable for those cycles, no read of 121 until the handshake.
REQ-027 Scenario: s_valid toggled every other cycle during LOAD -> o_we only on handshake cycles, addresses contiguous with no gaps or duplicates.
REQ-028 Scenario: i_rst asserted mid-LOAD at word 100 -> all outputs 0 next cycle; a new i_go restarts writes at address 0.
REQ-029 Scenario: with CONV_SEQ_TIMEOUT_EN and POLL_LIMIT=16, done never set -> o_err=1, o_done pulses, m_valid never asserts.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state encoding and control-register map for the convolution job sequencer
package conv_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CLEAR,
        START,
        POLL,
        RADDR,
        RWAIT,
        DRAIN,
        DONE
    } seq_state_t;

    localparam logic [13:0] CTRL_CLEAR_ADDR = 14'h3FFD;
    localparam logic [13:0] CTRL_START_ADDR = 14'h3FFE;
    localparam logic [13:0] CTRL_DONE_ADDR  = 14'h3FFF;

endpackage

// File: rtl/conv_seq_rd_buf.sv
// rtl/conv_seq_rd_buf.sv - one-entry result holding register with valid/ready handshake
module conv_seq_rd_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_tvalid_i,
    output logic             in_tready_o,
    input  logic [WIDTH-1:0] in_tdata_i,
    output logic             out_tvalid_o,
    input  logic             out_tready_i,
    output logic [WIDTH-1:0] out_tdata_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_tready_o  = !valid_q || out_tready_i;
    assign out_tvalid_o = valid_q;
    assign out_tdata_o  = data_q;

    // Data only moves on a load, so it stays stable while the consumer stalls.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_tready_i) begin
            valid_d = 1'b0;
        end
        if (in_tvalid_i && in_tready_o) begin
            valid_d = 1'b1;
            data_d  = in_tdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/conv_job_sequencer.sv
// rtl/conv_job_sequencer.sv - loads a convolution job, kicks the engine, polls for completion and streams results out
// Optional poll timeout enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv_job_sequencer
    import conv_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 14,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    LOAD_WORDS   = 288,
    parameter logic [ADDR_WIDTH-1:0] RESULT_BASE  = 14'h120,
    parameter int                    RESULT_WORDS = 2,
    parameter int                    POLL_LIMIT   = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_go,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  o_we,
    output logic                  o_re,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [ADDR_WIDTH-1:0] o_read_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int CNT_MAX = (LOAD_WORDS > POLL_LIMIT) ? LOAD_WORDS : POLL_LIMIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int KW      = $clog2(RESULT_WORDS + 1);

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  armed_q, armed_d;
    logic                  buf_in_valid;
    logic                  buf_in_ready;
    logic                  rd_last;

    function automatic logic [ADDR_WIDTH-1:0] result_addr(input logic [KW-1:0] k);
        return RESULT_BASE + ADDR_WIDTH'(k);
    endfunction

    assign s_ready      = (state_q == LOAD);
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
    assign o_we         = we_q;
    assign o_re         = re_q;
    assign o_write_addr = waddr_q;
    assign o_read_addr  = raddr_q;
    assign o_data       = wdata_q;
    assign rd_last      = (k_q == KW'(RESULT_WORDS - 1));
    // i_rdata trails the read by a cycle, so a poll read on the bus now arms sampling next cycle.
    assign armed_d      = (state_q == POLL) && re_q;

`ifdef CONV_SEQ_TIMEOUT_EN
    logic err_q, err_d;
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    // Every bus cycle is registered: each state sets up the transfer seen on the following cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        waddr_d      = waddr_q;
        raddr_d      = raddr_q;
        wdata_d      = wdata_q;
        buf_in_valid = 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_go) begin
                    state_d = LOAD;
                    cnt_d   = '0;
`ifdef CONV_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (s_valid) begin
                    we_d    = 1'b1;
                    waddr_d = ADDR_WIDTH'(cnt_q);
                    wdata_d = s_data;
                    if (cnt_q == CNT_W'(LOAD_WORDS - 1)) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CLEAR: begin
                we_d    = 1'b1;
                waddr_d = ADDR_WIDTH'(CTRL_CLEAR_ADDR);
                wdata_d = '0;
                state_d = START;
            end
            START: begin
                we_d    = 1'b1;
                waddr_d = ADDR_WIDTH'(CTRL_START_ADDR);
                wdata_d = DATA_WIDTH'(1);
                cnt_d   = '0;
                k_d     = '0;
                state_d = POLL;
            end
            POLL: begin
                if (armed_q && (i_rdata == DATA_WIDTH'(1))) begin
                    state_d = RADDR;
                    re_d    = 1'b1;
                    raddr_d = result_addr(k_q);
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(POLL_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
                else begin
                    re_d    = 1'b1;
                    raddr_d = ADDR_WIDTH'(CTRL_DONE_ADDR);
`ifdef CONV_SEQ_TIMEOUT_EN
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            RADDR: begin
                state_d = RWAIT;
            end
            RWAIT: begin
                buf_in_valid = 1'b1;
                if (buf_in_ready) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    if (rd_last) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        re_d    = 1'b1;
                        raddr_d = result_addr(k_q + KW'(1));
                        state_d = RADDR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
            armed_q <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            we_q    <= we_d;
            re_q    <= re_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wdata_q <= wdata_d;
            armed_q <= armed_d;
`ifdef CONV_SEQ_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    conv_seq_rd_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_rd_buf (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .in_tvalid_i (buf_in_valid),
        .in_tready_o (buf_in_ready),
        .in_tdata_i  ({rd_last, i_rdata}),
        .out_tvalid_o(m_valid),
        .out_tready_i(m_ready),
        .out_tdata_o ({m_last, m_data})
    );

endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb/tb_conv_job_sequencer.sv - directed self-checking bench for conv_job_sequencer
module tb_conv_job_sequencer;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LW = 288;
    localparam int RW = 2;
`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int PL         = 16;
    localparam int DONE_AFTER = 8;
`else
    localparam int PL         = 100000;
    localparam int DONE_AFTER = 50;
`endif
    localparam logic [31:0] RES0 = 32'hAAAA5555;
    localparam logic [31:0] RES1 = 32'h0F0F0F0F;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_go = 1'b0;
    logic          o_busy, o_done, o_err;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          o_we, o_re;
    logic [AW-1:0] o_write_addr, o_read_addr;
    logic [DW-1:0] o_data;
    logic [DW-1:0] i_rdata = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    conv_job_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_WORDS(LW),
        .RESULT_BASE(14'h120), .RESULT_WORDS(RW), .POLL_LIMIT(PL)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_go(i_go),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .o_we(o_we), .o_re(o_re), .o_write_addr(o_write_addr), .o_read_addr(o_read_addr),
        .o_data(o_data), .i_rdata(i_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    // Downstream engine model: done register rises on the DONE_AFTER-th poll read after a CLEAR write.
    bit done_en = 1'b1;
    int poll_seen = 0;
    always @(posedge clk) begin
        if (o_we && o_write_addr == 14'h3FFD) poll_seen <= 0;
        else if (o_re && o_read_addr == 14'h3FFF) poll_seen <= poll_seen + 1;
        if (!o_re) i_rdata <= '0;
        else if (o_read_addr == 14'h3FFF) i_rdata <= (done_en && poll_seen >= DONE_AFTER - 1) ? 32'd1 : 32'd0;
        else if (o_read_addr == 14'h0120) i_rdata <= RES0;
        else if (o_read_addr == 14'h0121) i_rdata <= RES1;
        else i_rdata <= 32'hDEADBEEF;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wn = 0, rn = 0, mn = 0, dn = 0, overlap = 0;
    logic [AW-1:0] wa [0:2047];
    logic [DW-1:0] wd [0:2047];
    int            wc [0:2047];
    logic [AW-1:0] ra [0:4095];
    logic [DW-1:0] md [0:63];
    logic          ml [0:63];
    always @(negedge clk) begin
        if (o_we) begin
            wa[wn] <= o_write_addr; wd[wn] <= o_data; wc[wn] <= cyc; wn <= wn + 1;
        end
        if (o_re) begin
            ra[rn] <= o_read_addr; rn <= rn + 1;
        end
        if (m_valid && m_ready) begin
            md[mn] <= m_data; ml[mn] <= m_last; mn <= mn + 1;
        end
        if (o_done) dn <= dn + 1;
        if (o_we && o_re) overlap <= overlap + 1;
    end

    function automatic logic [DW-1:0] pat(input int idx);
        return 32'hC0DE0000 + idx;
    endfunction

    function automatic int count_reads(input logic [AW-1:0] addr, input int from);
        int n = 0;
        for (int i = from; i < rn; i++) if (ra[i] == addr) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {o_we, o_re, s_ready, m_valid, m_last, o_busy, o_done, o_err}, 8'h00);
        check({tag, "_addr"}, {o_write_addr, o_read_addr}, 28'h0);
        check({tag, "_odata"}, o_data, 32'h0);
        check({tag, "_mdata"}, m_data, 32'h0);
    endtask

    task automatic pulse_go();
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
    endtask

    task automatic load_words(input int n, input bit toggle);
        int  idx = 0;
        int  c = 0;
        bit  hs;
        while (idx < n && c < 4 * n + 20) begin
            s_valid = toggle ? ~c[0] : 1'b1;
            s_data  = pat(idx);
            hs = s_valid && s_ready;
            tick();
            c++;
            if (hs) idx++;
        end
        s_valid = 1'b0;
        check("load_count", idx, n);
    endtask

    task automatic wait_for_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (o_done) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
        tick();
    endtask

    task automatic check_load_writes(input int w0, input int step);
        for (int i = 0; i < LW; i++) begin
            check("wr_addr", wa[w0 + i], i);
            check("wr_data", wd[w0 + i], pat(i));
            check("wr_cycle", wc[w0 + i] - wc[w0], i * step);
        end
        check("clear_wr", {wa[w0 + LW], wd[w0 + LW]}, {14'h3FFD, 32'h0});
        check("start_wr", {wa[w0 + LW + 1], wd[w0 + LW + 1]}, {14'h3FFE, 32'h1});
        check("ctrl_wr_cycles", {wc[w0 + LW] - wc[w0 + LW - 1], wc[w0 + LW + 1] - wc[w0 + LW]}, {32'd1, 32'd1});
    endtask

    task automatic check_results(input int w0, input int r0, input int m0, input int d0);
        int polls;
        check("job_writes", wn - w0, LW + 2);
        polls = count_reads(14'h3FFF, r0);
        check("poll_reads_range", (polls >= DONE_AFTER) && (polls <= DONE_AFTER + 2), 1'b1);
        check("result_reads", rn - r0 - polls, 2);
        check("read_order", {ra[rn - 2], ra[rn - 1]}, {14'h0120, 14'h0121});
        check("m_count", mn - m0, 2);
        check("m_word0", {ml[m0], md[m0]}, {1'b0, RES0});
        check("m_word1", {ml[m0 + 1], md[m0 + 1]}, {1'b1, RES1});
        check("done_pulses", dn - d0, 1);
        check("err_clear", o_err, 1'b0);
    endtask

    initial begin
        int w0, r0, m0, d0;

        tick();
        tick();
        check_all_zero("reset");
        i_rst = 1'b0;
        tick();
        check_all_zero("idle");

        // Job 1: back-to-back loading, stray i_go while busy.
        w0 = wn; r0 = rn; m0 = mn; d0 = dn;
        pulse_go();
        check("busy_load", {o_busy, s_ready}, 2'b11);
        load_words(LW, 1'b0);
        check("s_ready_drop", s_ready, 1'b0);
        pulse_go();
        wait_for_done("job1_done", 1000);
        check_load_writes(w0, 1);
        check_results(w0, r0, m0, d0);
        check("idle_after_job1", o_busy, 1'b0);

        // Job 2: consumer stalls on word 0.
        w0 = wn; r0 = rn; m0 = mn; d0 = dn;
        m_ready = 1'b0;
        pulse_go();
        load_words(LW, 1'b0);
        for (int i = 0; i < 1000 && !m_valid; i++) tick();
        check("stall_valid_seen", m_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_hold", {m_valid, m_last, m_data}, {1'b1, 1'b0, RES0});
        end
        check("stall_no_121", count_reads(14'h0121, r0), 0);
        m_ready = 1'b1;
        wait_for_done("job2_done", 200);
        check_results(w0, r0, m0, d0);

        // Job 3: s_valid toggles every other cycle.
        w0 = wn; r0 = rn; m0 = mn; d0 = dn;
        pulse_go();
        load_words(LW, 1'b1);
        wait_for_done("job3_done", 1000);
        check_load_writes(w0, 2);
        check_results(w0, r0, m0, d0);

        // Job 4: reset at word 100, then a fresh job restarts at address 0.
        pulse_go();
        load_words(100, 1'b0);
        i_rst = 1'b1;
        tick();
        check_all_zero("mid_reset");
        i_rst = 1'b0;
        w0 = wn; r0 = rn;
        for (int i = 0; i < 5; i++) tick();
        check("no_bus_after_reset", {wn - w0, rn - r0}, 64'h0);
        w0 = wn; r0 = rn; m0 = mn; d0 = dn;
        pulse_go();
        load_words(LW, 1'b0);
        wait_for_done("job5_done", 1000);
        check_load_writes(w0, 1);
        check_results(w0, r0, m0, d0);

`ifdef CONV_SEQ_TIMEOUT_EN
        // Job 6: engine never finishes, timeout path.
        done_en = 1'b0;
        m0 = mn; d0 = dn;
        pulse_go();
        load_words(LW, 1'b0);
        wait_for_done("timeout_done", 200);
        check("timeout_err", o_err, 1'b1);
        check("timeout_no_results", mn - m0, 0);
        check("timeout_done_pulses", dn - d0, 1);
        done_en = 1'b1;
`endif

        check("we_re_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
